sum_accum: RTL

- Downstream consumer of the 8-bit ripple adder's 9-bit sum output (sum plus carry).
- Accepts a valid/ready stream of 9-bit sums and accumulates N_TERMS of them, or fewer if in_last ends the group early, into an ACC_W-bit total.
- Emits the total with a term count and a sticky overflow flag on a valid/ready output port.
- Sits between the 8-bit adder datapath and any consumer of multi-term totals, such as a checksum or averaging stage.

---
 rtl/sum_accum_pkg.sv | 19 +
 rtl/sum_accum_if.sv | 30 +++
 rtl/sum_accum_acc_add.sv | 23 ++
 rtl/sum_accum.sv | 108 ++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and default widths for the sum accumulator.
//   state_t    : controller state, 1-bit encoded
//   cnt_width  : width needed to hold a term count of 0..n
package sum_accum_pkg;

    localparam int IN_W_DEF    = 9;
    localparam int ACC_W_DEF   = 16;
    localparam int N_TERMS_DEF = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Input and result streams of the sum accumulator.
//   in_valid/in_ready/in_data/in_last       : incoming 9-bit sums
//   out_valid/out_ready/out_sum/out_count/out_ovf : group result
//   master : the side feeding sums and consuming results
//   slave  : the accumulator itself
interface sum_accum_if #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 16,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/sum_accum_acc_add.sv
// acc_add: W-bit ripple-carry adder with carry-out, one full-adder cell per bit.
//   a, b : operands
//   s    : sum modulo 2^W
//   cout : carry out of bit W-1
module acc_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];
endmodule

// File: rtl/sum_accum.sv
// sum_accum: accumulates up to N_TERMS incoming sums (fewer when in_last ends
// the group) and presents the total, term count and sticky overflow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort of the group in progress (ignored while a
//           result is waiting to be handed off)
//   bus   : input/result streams, see sum_accum_if
//
// state | meaning
// ACCUM | accepting sums into acc, in_ready=1
// DONE  | result held on out_*, out_valid=1, waiting for out_ready
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CNT_W   = cnt_width(N_TERMS)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    sum_accum_if.slave bus
);
    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;
    logic             last_term;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    acc_add #(.W(ACC_W)) u_add (
        .a    (acc),
        .b    (ACC_W'(bus.in_data)),
        .s    (sum_nxt),
        .cout (carry)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        beat          = 1'b0;
        last_term     = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                beat         = bus.in_valid;
                // in_last on the N_TERMS-th beat is the same single group end
                last_term    = (cnt_inc == CNT_W'(N_TERMS)) || bus.in_last;
                if (beat && last_term && !flush) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (state == ACCUM) begin
            if (flush) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (beat) begin
                if (last_term) begin
                    out_sum_q   <= sum_nxt;
                    out_count_q <= cnt_inc;
                    out_ovf_q   <= ovf | carry;
                end else begin
                    acc <= sum_nxt;
                    cnt <= cnt_inc;
                    ovf <= ovf | carry;
                end
            end
        end else if (bus.out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
